vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator. Samples a VGA_HS / VGA_VS / VGA_BLANK_n triple synchronous to clk50 and recovers the active-pixel coordinates. Measures line length and lines per frame, and declares lock once consecutive frames match the expected 640x480 timing (1600 clk50 per line, 525 lines). Used for loopback self-checking of the video path and as a coordinate source for downstream pixel checkers.

---
 rtl/vga_sync_decoder_if.sv | 25 ++
 rtl/vga_sync_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_decoder_if.sv
// VGA sync/blank triple seen by the decoder together with the decoded
// coordinate, measurement and lock outputs it returns.
interface vga_sync_decoder_if;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_n;
  logic       active;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [10:0] line_len;
  logic [9:0] frame_lines;
  logic       locked;
  logic       lock_lost;
  logic [7:0] err_count;

  modport master (
    output VGA_HS, VGA_VS, VGA_BLANK_n,
    input  active, pix_x, pix_y, line_len, frame_lines, locked, lock_lost, err_count
  );

  modport slave (
    input  VGA_HS, VGA_VS, VGA_BLANK_n,
    output active, pix_x, pix_y, line_len, frame_lines, locked, lock_lost, err_count
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and line/frame timing from a VGA sync triple and
// tracks timing lock. Define VGA_SYNC_DECODER_ERRCNT_EN to build the bad-frame counter.
module vga_sync_decoder #(
  parameter logic [10:0] EXP_HTOTAL  = 11'd1600,
  parameter logic [9:0]  EXP_VTOTAL  = 10'd525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic               clk50,
  input logic               reset,
  vga_sync_decoder_if.slave vga
);

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  logic        hs_d_q, vs_d_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] hpos_q, hpos_d;
  logic [9:0]  vpos_q, vpos_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic        hprimed_q, hprimed_d;
  logic        vprimed_q, vprimed_d;
  logic        frame_bad_q, frame_bad_d;
  logic [2:0]  good_cnt_q, good_cnt_d;
  lock_state_e state_q, state_d;

  logic        active_q;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q;
  logic [10:0] line_len_q, line_len_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic        locked_q;
  logic        lock_lost_q, lock_lost_d;

  logic        hs_fall_s, vs_fall_s, blank_fall_s, hs_lost_s;
  logic [11:0] hcnt_inc_s;
  logic [9:0]  line_cnt_upd_s;
  logic        frame_bad_upd_s;
  logic        frame_good_s, frame_bad_ev_s;

  // Edge detection, line/frame measurement and coordinate next-state
  always_comb begin
    hs_fall_s    = hs_d_q & ~vga.VGA_HS;
    vs_fall_s    = vs_d_q & ~vga.VGA_VS;
    blank_fall_s = active_q & ~vga.VGA_BLANK_n;
    hcnt_inc_s   = {1'b0, hcnt_q} + 12'd1;
    hs_lost_s    = (hcnt_q == 11'd2047);

    // The line update is applied before the frame evaluation so a coincident
    // HS/VS fall judges the frame with the final line already counted.
    if (hs_fall_s) begin
      hcnt_d          = 11'd0;
      line_len_d      = hcnt_inc_s[11] ? 11'd2047 : hcnt_inc_s[10:0];
      line_cnt_upd_s  = (line_cnt_q == 10'd1023) ? line_cnt_q : line_cnt_q + 10'd1;
      frame_bad_upd_s = frame_bad_q | (hprimed_q & (hcnt_inc_s != {1'b0, EXP_HTOTAL}));
      hprimed_d       = 1'b1;
    end else begin
      hcnt_d          = hs_lost_s ? hcnt_q : hcnt_q + 11'd1;
      line_len_d      = line_len_q;
      line_cnt_upd_s  = line_cnt_q;
      frame_bad_upd_s = frame_bad_q;
      hprimed_d       = hprimed_q;
    end

    frame_good_s   = vs_fall_s & vprimed_q & ~frame_bad_upd_s & (line_cnt_upd_s == EXP_VTOTAL);
    frame_bad_ev_s = vs_fall_s & ~frame_good_s;

    if (vs_fall_s) begin
      frame_lines_d = line_cnt_upd_s;
      line_cnt_d    = 10'd0;
      frame_bad_d   = 1'b0;
      vprimed_d     = hprimed_d;
      vpos_d        = 10'd0;
    end else begin
      frame_lines_d = frame_lines_q;
      line_cnt_d    = line_cnt_upd_s;
      frame_bad_d   = frame_bad_upd_s;
      vprimed_d     = vprimed_q;
      vpos_d        = (blank_fall_s && (vpos_q != 10'd1023)) ? vpos_q + 10'd1 : vpos_q;
    end

    if (vga.VGA_BLANK_n) begin
      hpos_d  = (hpos_q == 11'd2047) ? hpos_q : hpos_q + 11'd1;
      pix_x_d = hpos_q[10:1];
    end else begin
      hpos_d  = 11'd0;
      pix_x_d = 10'd0;
    end
  end

  // Sync history, counters and registered measurement/coordinate outputs
  always_ff @(posedge clk50) begin
    if (reset) begin
      hs_d_q        <= 1'b1;
      vs_d_q        <= 1'b1;
      hcnt_q        <= 11'd0;
      hpos_q        <= 11'd0;
      vpos_q        <= 10'd0;
      line_cnt_q    <= 10'd0;
      hprimed_q     <= 1'b0;
      vprimed_q     <= 1'b0;
      frame_bad_q   <= 1'b0;
      active_q      <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      line_len_q    <= 11'd0;
      frame_lines_q <= 10'd0;
    end else begin
      hs_d_q        <= vga.VGA_HS;
      vs_d_q        <= vga.VGA_VS;
      hcnt_q        <= hcnt_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      line_cnt_q    <= line_cnt_d;
      hprimed_q     <= hprimed_d;
      vprimed_q     <= vprimed_d;
      frame_bad_q   <= frame_bad_d;
      active_q      <= vga.VGA_BLANK_n;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= vpos_q;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  // Lock FSM next-state: count good frames, drop lock on a bad frame or lost HS
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    lock_lost_d = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (frame_good_s) begin
          good_cnt_d = 3'd1;
          state_d    = (LOCK_TGT == 3'd1) ? LOCKED : ACQUIRE;
        end else begin
          state_d = UNLOCKED;
        end
      end
      ACQUIRE: begin
        if (frame_good_s) begin
          good_cnt_d = good_cnt_q + 3'd1;
          state_d    = ((good_cnt_q + 3'd1) == LOCK_TGT) ? LOCKED : ACQUIRE;
        end else if (frame_bad_ev_s) begin
          good_cnt_d = 3'd0;
          state_d    = UNLOCKED;
        end else begin
          state_d = ACQUIRE;
        end
      end
      LOCKED: begin
        if (frame_bad_ev_s || hs_lost_s) begin
          good_cnt_d  = 3'd0;
          state_d     = UNLOCKED;
          lock_lost_d = 1'b1;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        good_cnt_d = 3'd0;
        state_d    = UNLOCKED;
      end
    endcase
  end

  // Lock FSM state register with registered lock indications
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      good_cnt_q  <= 3'd0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      locked_q    <= (state_d == LOCKED);
      lock_lost_q <= lock_lost_d;
    end
  end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Bad frames only count once a full frame could have been observed
  always_comb begin
    if (frame_bad_ev_s && vprimed_q && (err_cnt_q != 8'd255)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Saturating bad-frame counter register
  always_ff @(posedge clk50) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign vga.err_count = err_cnt_q;
`else
  assign vga.err_count = 8'd0;
`endif

  assign vga.active      = active_q;
  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.line_len    = line_len_q;
  assign vga.frame_lines = frame_lines_q;
  assign vga.locked      = locked_q;
  assign vga.lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomised bench for vga_sync_decoder with a timestamp/queue based reference
// model; small line/frame totals keep the run short.
module tb_vga_sync_decoder;
  localparam int HT = 40;
  localparam int VT = 10;
  localparam int LF = 2;

  logic clk50 = 1'b0;
  logic reset;
  always #5 clk50 = ~clk50;

  vga_sync_decoder_if vif();

  vga_sync_decoder #(
    .EXP_HTOTAL (11'(HT)),
    .EXP_VTOTAL (10'(VT)),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk50(clk50),
    .reset(reset),
    .vga  (vif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rst_at   = -1;

  // Reference model state: time stamps, per-frame line list, lock streak
  int  h_origin;
  bit  h_seen;
  bit  prev_hs, prev_vs, prev_bl;
  int  line_q[$];
  bit  frame_primed;
  int  act_run;
  int  bfalls;
  int  streak;
  bit  lock_m;
  int  err_m;
  int  e_active, e_px, e_py, e_len, e_flines, e_locked, e_lost;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic model_step(input bit rst, input bit hs, input bit vs, input bit bl);
    bit hs_fall, vs_fall, b_fall, good;
    int hcnt_now;
    if (rst) begin
      h_origin = cyc; h_seen = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1; prev_bl = 1'b0;
      line_q.delete(); frame_primed = 1'b0; act_run = 0; bfalls = 0;
      streak = 0; lock_m = 1'b0; err_m = 0;
      e_active = 0; e_px = 0; e_py = 0; e_len = 0; e_flines = 0; e_locked = 0; e_lost = 0;
      return;
    end
    hs_fall  = prev_hs && !hs;
    vs_fall  = prev_vs && !vs;
    b_fall   = prev_bl && !bl;
    hcnt_now = imin(cyc - h_origin - 1, 2047);
    good     = 1'b0;
    e_active = int'(bl);
    e_px     = bl ? (imin(act_run, 2047) / 2) : 0;
    e_py     = imin(bfalls, 1023);
    e_lost   = 0;
    if (hs_fall) begin
      e_len = imin(cyc - h_origin, 2047);
      line_q.push_back(h_seen ? (cyc - h_origin) : -1);
      h_seen   = 1'b1;
      h_origin = cyc;
    end
    if (vs_fall) begin
      good = frame_primed && (line_q.size() == VT);
      foreach (line_q[i]) if (line_q[i] != -1 && line_q[i] != HT) good = 1'b0;
      e_flines = imin(line_q.size(), 1023);
      if (frame_primed && !good) err_m = imin(err_m + 1, 255);
      line_q.delete();
      frame_primed = h_seen;
    end
    if (lock_m) begin
      if (hcnt_now == 2047 || (vs_fall && !good)) begin
        lock_m = 1'b0; streak = 0; e_lost = 1;
      end
    end else if (vs_fall) begin
      if (good) begin
        streak++;
        if (streak >= LF) lock_m = 1'b1;
      end else begin
        streak = 0;
      end
    end
    e_locked = int'(lock_m);
    if (vs_fall) bfalls = 0;
    else if (b_fall) bfalls++;
    act_run = bl ? act_run + 1 : 0;
    prev_hs = hs; prev_vs = vs; prev_bl = bl;
  endtask

  task automatic tick(input bit rst, input bit hs, input bit vs, input bit bl);
    int e_err;
    @(negedge clk50);
    reset = rst; vif.VGA_HS = hs; vif.VGA_VS = vs; vif.VGA_BLANK_n = bl;
    model_step(rst, hs, vs, bl);
    @(posedge clk50);
    #1;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    e_err = err_m;
`else
    e_err = 0;
`endif
    check_val("active", int'(vif.active), e_active);
    check_val("pix_x", int'(vif.pix_x), e_px);
    check_val("pix_y", int'(vif.pix_y), e_py);
    check_val("line_len", int'(vif.line_len), e_len);
    check_val("frame_lines", int'(vif.frame_lines), e_flines);
    check_val("locked", int'(vif.locked), e_locked);
    check_val("lock_lost", int'(vif.lock_lost), e_lost);
    check_val("err_count", int'(vif.err_count), e_err);
    cyc++;
  endtask

  task automatic send_line(input int len, input int hs_low, input bit vs_low, input bit act,
                           input int a0, input int aw, input bit toggle);
    bit bl;
    for (int k = 0; k < len; k++) begin
      bl = act && (k >= a0) && (k < a0 + aw);
      if (toggle) bl = (k >= 8) && (k % 2 == 0);
      tick(cyc == rst_at, k >= hs_low, !vs_low, bl);
    end
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                            input int a0, input int aw);
    for (int l = 0; l < nlines; l++) begin
      send_line((l == bad_line) ? bad_len : HT, 4, l < 2, (l >= 3) && (l < nlines - 1),
                a0, aw, 1'b0);
    end
  endtask

  initial begin
    int nl, bl_idx, bl_len, a0, aw, r;
    reset = 1'b1; vif.VGA_HS = 1'b1; vif.VGA_VS = 1'b1; vif.VGA_BLANK_n = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);

    // Acquisition from reset: lock after the third VS fall
    send_frame(VT, -1, HT, 8, 24);
    send_frame(VT, -1, HT, 8, 24);
    check_val("unlocked_after_2vs", int'(vif.locked), 0);
    send_frame(VT, -1, HT, 8, 24);
    check_val("locked_after_3vs", int'(vif.locked), 1);
    check_val("line_len_nominal", int'(vif.line_len), HT);
    check_val("frame_lines_nominal", int'(vif.frame_lines), VT);
    send_frame(VT, -1, HT, 8, 24);

    // One stretched line: lose lock at the next VS, regain two frames later
    send_frame(VT, 5, HT + 1, 8, 24);
    send_frame(VT, -1, HT, 8, 24);
    send_frame(VT, -1, HT, 8, 24);
    check_val("relock_pending", int'(vif.locked), 0);
    send_frame(VT, -1, HT, 8, 24);
    check_val("relocked", int'(vif.locked), 1);

    // HS held high with a full-width active span (pix_x reaches 639)
    send_line(2104, 4, 1'b0, 1'b1, 8, 1280, 1'b0);
    check_val("hs_lost_unlock", int'(vif.locked), 0);
    for (int i = 0; i < 4; i++) send_frame(VT, -1, HT, 8, 24);

    // Single-cycle reset mid-frame, then reacquire after three VS falls
    rst_at = cyc + 150;
    send_frame(VT, -1, HT, 8, 24);
    send_frame(VT, -1, HT, 8, 24);
    send_frame(VT, -1, HT, 8, 24);
    check_val("reset_relock_pending", int'(vif.locked), 0);
    send_frame(VT, -1, HT, 8, 24);
    check_val("reset_relocked", int'(vif.locked), 1);
    rst_at = -1;

    // Rapid blank toggling drives pix_y past 479 into saturation
    send_line(2200, 4, 1'b0, 1'b0, 0, 0, 1'b1);
    send_frame(VT, -1, HT, 8, 24);

    // Short-by-one frames never lock
    for (int i = 0; i < 4; i++) send_frame(VT - 1, -1, HT, 8, 24);
    check_val("short_frame_unlocked", int'(vif.locked), 0);
    check_val("short_frame_lines", int'(vif.frame_lines), VT - 1);

    // Enough bad frames to saturate the error counter
    for (int i = 0; i < 260; i++) begin
      send_line(HT, 4, 1'b1, 1'b0, 8, 24, 1'b0);
      send_line(HT, 4, 1'b0, 1'b0, 8, 24, 1'b0);
    end
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    check_val("err_saturated", int'(vif.err_count), 255);
`else
    check_val("err_absent", int'(vif.err_count), 0);
`endif

    // Randomised frames: occasional odd line/frame lengths and resets
    for (int f = 0; f < 30; f++) begin
      r      = int'($urandom_range(0, 9));
      nl     = (r == 0) ? VT - 1 : ((r == 1) ? VT + 1 : VT);
      bl_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      bl_len = ($urandom_range(0, 1) == 1) ? HT + 1 : HT - 1;
      a0     = int'($urandom_range(5, 10));
      aw     = int'($urandom_range(1, HT - a0 - 1));
      if ($urandom_range(0, 19) == 0) rst_at = cyc + int'($urandom_range(1, 300));
      send_frame(nl, bl_idx, bl_len, a0, aw);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
